// File: rtl/datastore_reader.sv
// -----------------------------------------------------------------------------
// datastore_reader
//
// Read side of the 128-bit nibble datastore. An accepted start takes a
// snapshot of the datastore, then streams count nibbles (clamped to NIBBLES)
// in ascending index order over a valid/ready handshake. This feeds the
// A5/1 key/frame loader and the display path.
//
// Optional feature macro: DATASTORE_READER_ASCII_EN
//   defined   : out_data is the uppercase ASCII character for the nibble
//   undefined : out_data = {4'b0000, nibble}
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         burst request, honoured only in IDLE
//   datastore_in  datastore contents, nibble i at [4i+3:4i]
//   count         number of nibbles to emit, sampled with start
//   out_valid     out_data / out_index / out_last are valid
//   out_ready     consumer accepts the current beat
//   out_data      current nibble (raw or ASCII)
//   out_index     index of the current nibble
//   out_last      current beat is the final beat of the burst
//   busy          high in SEND and FINISH
//   done          one-cycle pulse when the burst completes
//
// State  | meaning
// IDLE   | waiting for start
// SEND   | presenting nibble idx until the consumer takes it
// FINISH | burst complete, done pulse
// -----------------------------------------------------------------------------
module datastore_reader #(
    parameter int NIBBLES = 32,
    parameter int IDX_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] datastore_in,
    input  logic [IDX_W:0]       count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int             LEN_W   = IDX_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NIBBLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [4*NIBBLES-1:0] shadow_q, shadow_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [LEN_W-1:0]     count_clamped;
    logic [IDX_W+1:0]     bit_sel;
    logic [3:0]           nibble;
    logic                 is_last;

    function automatic logic [7:0] format_nibble(input logic [3:0] n);
`ifdef DATASTORE_READER_ASCII_EN
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};   // 'A' - 10
        end
`else
        return {4'b0000, n};
`endif
    endfunction

    assign count_clamped = (count > LEN_MAX) ? LEN_MAX : count;
    assign bit_sel       = {idx_q, 2'b00};
    assign nibble        = shadow_q[bit_sel +: 4];
    // len_q is never zero while in SEND, so len_q - 1 cannot underflow there.
    assign is_last       = ({1'b0, idx_q} == (len_q - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        len_d     = len_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_index = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = datastore_in;
                    len_d    = count_clamped;
                    idx_d    = '0;
                    state_d  = (count_clamped == '0) ? FINISH : SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = format_nibble(nibble);
                out_index = idx_q;
                out_last  = is_last;
                busy      = 1'b1;
                if (out_ready) begin
                    if (is_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
